// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Ownership states, the counter width and the default starvation bound.
package dmem_arb_pkg;

    // Which requester currently drives the data memory.
    typedef enum logic {
        ST_CORE = 1'b0,
        ST_HOST = 1'b1
    } arb_state_t;

    // Wide enough for any legal STARVE_MAX (1..15).
    localparam int CNT_W = 4;

    // Default bound on host waiting and on host burst length.
    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over enable; the count holds once it reaches MAX.
module arb_sat_counter #(
    parameter int W   = 4,
    parameter int MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    // Count enabled cycles, stop at MAX, restart from zero on clear or reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != MAX_V)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory.
// The core load/store path has default priority; a host port preloads
// operands and reads back results. A saturating wait counter bounds how
// long a pending host request can be starved by continuous core traffic.
// The core is stalled only while the host owns the memory.
//
// Optional feature: define DMEM_ARB_HOST_BURST_EN to let a host holding
// host_lock keep the memory for up to STARVE_MAX consecutive accesses,
// after which one core cycle is forced. Without it host_lock is ignored and
// every host ownership lasts exactly one cycle.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int STARVE_MAX = STARVE_MAX_DEF  // legal range 1..15
) (
    input  logic          CLK,
    input  logic          Reset,
    // core load/store path
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,
    // host port
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    input  logic          host_lock,
    output logic          host_ack,
    output logic [DW-1:0] host_rdata,
    // data memory
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    // Value of a counter on the last cycle before its limit takes effect.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_MAX - 1);

    arb_state_t       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             go_host;
    logic             stay_host;
    logic             wait_en;
    logic             wait_clr;

    // Host takes over when the core is idle or the host has waited long enough.
    always_comb begin
        go_host  = host_req && (!core_req || (wait_cnt == CNT_LAST));
        wait_en  = (state == ST_CORE) && host_req && core_req;
        wait_clr = (state == ST_HOST) || go_host;
    end

    arb_sat_counter #(
        .W   (CNT_W),
        .MAX (STARVE_MAX)
    ) u_wait_cnt (
        .clk   (CLK),
        .rst   (Reset),
        .en    (wait_en),
        .clr   (wait_clr),
        .count (wait_cnt)
    );

`ifdef DMEM_ARB_HOST_BURST_EN
    logic [CNT_W-1:0] burst_cnt;
    logic             burst_en;
    logic             burst_clr;

    // Count consecutive host cycles; any core cycle ends the burst.
    always_comb begin
        burst_en  = (state == ST_HOST);
        burst_clr = (state == ST_CORE);
        stay_host = host_lock && host_req && (burst_cnt < CNT_LAST);
    end

    arb_sat_counter #(
        .W   (CNT_W),
        .MAX (STARVE_MAX)
    ) u_burst_cnt (
        .clk   (CLK),
        .rst   (Reset),
        .en    (burst_en),
        .clr   (burst_clr),
        .count (burst_cnt)
    );
`else
    // Bursts disabled: the lock request has no effect.
    logic unused_host_lock;
    assign unused_host_lock = host_lock;
    assign stay_host        = 1'b0;
`endif

    // Ownership FSM: host cycles are single (or bounded bursts), then back to the core.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= ST_CORE;
        end else begin
            case (state)
                ST_CORE: if (go_host)    state <= ST_HOST;
                ST_HOST: if (!stay_host) state <= ST_CORE;
                default:                 state <= ST_CORE;
            endcase
        end
    end

    // Steer the memory port to the owner and derive the handshake outputs.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        mem_we     = core_req && core_we;
        mem_addr   = core_addr;
        mem_wdata  = core_wdata;
        host_ack   = 1'b0;
        core_stall = 1'b0;
        if (state == ST_HOST) begin
            mem_we     = host_we;
            mem_addr   = host_addr;
            mem_wdata  = host_wdata;
            host_ack   = 1'b1;
            core_stall = core_req;
        end
    end

    // Read data is shared; each side only trusts it when it owns the memory.
    assign core_rdata = mem_rdata;
    assign host_rdata = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural
// 256x8 data memory (combinational read, write on the rising edge).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Covers both builds of DMEM_ARB_HOST_BURST_EN.
module tb_dmem_arbiter;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       core_req, core_we;
    logic [7:0] core_addr, core_wdata, core_rdata;
    logic       core_stall;
    logic       host_req, host_we, host_lock, host_ack;
    logic [7:0] host_addr, host_wdata, host_rdata;
    logic       mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256];

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    dmem_arbiter #(
        .AW         (8),
        .DW         (8),
        .STARVE_MAX (4)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_lock  (host_lock),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge CLK);
        #1;
    endtask

    task automatic sample;
        @(negedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] ackv;
        logic [5:0]  ack6, stall6;
        logic [4:0]  ack5, stall5;
        logic        got_ack;
        int          idx;

        // Reset with a core store on the bus
        Reset = 1'b1;
        core_req = 1'b1; core_we = 1'b1; core_addr = 8'h10; core_wdata = 8'hA5;
        host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00; host_lock = 1'b0;
        sample;
        check("rst_mem_we",     32'(mem_we),     32'd1);
        check("rst_mem_addr",   32'(mem_addr),   32'h10);
        check("rst_mem_wdata",  32'(mem_wdata),  32'hA5);
        check("rst_core_stall", 32'(core_stall), 32'd0);
        check("rst_host_ack",   32'(host_ack),   32'd0);
        next_cycle;
        Reset = 1'b0; core_we = 1'b0;
        sample;
        check("core_load_10", 32'(core_rdata), 32'hA5);
        check("core_load_stall", 32'(core_stall), 32'd0);

        // Host write with core idle: one-cycle latency
        next_cycle;
        core_req = 1'b0;
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h1F; host_wdata = 8'h3C;
        sample;
        check("hw_ack_req_cycle", 32'(host_ack), 32'd0);
        next_cycle;
        sample;
        check("hw_ack",       32'(host_ack),  32'd1);
        check("hw_mem_we",    32'(mem_we),    32'd1);
        check("hw_mem_addr",  32'(mem_addr),  32'h1F);
        check("hw_mem_wdata", 32'(mem_wdata), 32'h3C);
        check("hw_stall_idle", 32'(core_stall), 32'd0);
        next_cycle;
        host_req = 1'b0; host_we = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_addr = 8'h1F;
        sample;
        check("hw_back_core_ack", 32'(host_ack),   32'd0);
        check("hw_readback",      32'(core_rdata), 32'h3C);

        // Continuous core traffic: host served after STARVE_MAX cycles
        next_cycle;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
        got_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                next_cycle;
                if (got_ack) host_req = 1'b0;
            end
            sample;
            ack6[i]   = host_ack;
            stall6[i] = core_stall;
            if (i == 0) check("starve_core_rdata", 32'(core_rdata), 32'h3C);
            if (host_ack) begin
                check("starve_host_rdata", 32'(host_rdata), 32'hA5);
                got_ack = 1'b1;
            end
        end
        check("starve_ack_pattern",   32'(ack6),   32'b010000);
        check("starve_stall_pattern", 32'(stall6), 32'b010000);

        // Same-address writes from both sides: core first, host second
        next_cycle;
        core_req = 1'b1; core_we = 1'b1; core_addr = 8'h05; core_wdata = 8'h11;
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h05; host_wdata = 8'h22;
        sample;
        check("col_core_wdata", 32'(mem_wdata), 32'h11);
        check("col_core_we",    32'(mem_we),    32'd1);
        check("col_ack0",       32'(host_ack),  32'd0);
        next_cycle;
        core_req = 1'b0; core_we = 1'b0;
        sample;
        check("col_ack1",   32'(host_ack), 32'd0);
        check("col_we1",    32'(mem_we),   32'd0);
        next_cycle;
        sample;
        check("col_ack2",        32'(host_ack),  32'd1);
        check("col_host_wdata",  32'(mem_wdata), 32'h22);
        check("col_host_addr",   32'(mem_addr),  32'h05);
        next_cycle;
        host_req = 1'b0; host_we = 1'b0;
        core_req = 1'b1; core_addr = 8'h05;
        sample;
        check("col_final", 32'(core_rdata), 32'h22);

        // Preload 0x00..0x09 through the core path
        for (int i = 0; i < 10; i++) begin
            next_cycle;
            core_req = 1'b1; core_we = 1'b1; core_addr = 8'(i); core_wdata = 8'(i) ^ 8'h5A;
            sample;
        end

        // Ten locked host reads
        idx = 0;
        ackv = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            next_cycle;
            core_req  = 1'b0; core_we = 1'b0;
            host_req  = (idx < 10);
            host_we   = 1'b0;
            host_addr = 8'(idx);
            host_lock = (idx < 9);
            sample;
            ackv[cyc] = host_ack;
            if (host_ack) begin
                check($sformatf("rd_data_%0d", idx), 32'(host_rdata), 32'(8'(idx) ^ 8'h5A));
                idx++;
            end
        end
        check("rd_count", 32'(idx), 32'd10);
`ifdef DMEM_ARB_HOST_BURST_EN
        check("rd_ack_pattern", 32'(ackv), 32'h01BDE);
`else
        check("rd_ack_pattern", 32'(ackv), 32'hAAAAA);
`endif

        // Reset pulsed during a host write while the core is requesting
        next_cycle;
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h30; host_wdata = 8'h77; host_lock = 1'b0;
        sample;
        check("rh_ack_pre", 32'(host_ack), 32'd0);
        next_cycle;
        core_req = 1'b1; core_we = 1'b0; core_addr = 8'h10;
        Reset = 1'b1;
        sample;
        check("rh_ack_host",   32'(host_ack),   32'd1);
        check("rh_stall_host", 32'(core_stall), 32'd1);
        check("rh_we_host",    32'(mem_we),     32'd1);
        for (int r = 0; r < 5; r++) begin
            next_cycle;
            Reset = 1'b0;
            sample;
            ack5[r]   = host_ack;
            stall5[r] = core_stall;
        end
        check("rh_ack_after",   32'(ack5),   32'b10000);
        check("rh_stall_after", 32'(stall5), 32'b10000);
        next_cycle;
        host_req = 1'b0; host_we = 1'b0;
        core_addr = 8'h30;
        sample;
        check("rh_write_kept", 32'(core_rdata), 32'h77);
        check("rh_final_ack",  32'(host_ack),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter sharing the single-port 256x8 data memory (DataMem) between the CPU core's load/store path and a host port used for preloading operands and reading back results (program 1 Hamming messages/encodings, programs 2/3 data). Sits between TopLevel's load/store datapath and the data memory instance. Core has default priority. A saturating wait counter bounds host starvation. Core stalls only while the host owns the memory.

## Interface
Parameters:
- AW, 8, address width (256 bytes)
- DW, 8, data width
- STARVE_MAX, 4, max cycles a pending host request waits behind core traffic; also max host burst length; legal range 1..15

Ports:
- CLK  in  1  clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- core_req  in  1  core load/store this cycle
- core_we  in  1  1 = store
- core_addr  in  AW  core address
- core_wdata  in  DW  store data
- core_rdata  out  DW  load data (combinational from mem_rdata)
- core_stall  out  1  core must hold its request and PC
- host_req  in  1  host access request, held until host_ack
- host_we  in  1  1 = write
- host_addr  in  AW  host address
- host_wdata  in  DW  host write data
- host_lock  in  1  request burst (used only with DMEM_ARB_HOST_BURST_EN)
- host_ack  out  1  host access performed this cycle
- host_rdata  out  DW  host read data, valid while host_ack=1
- mem_we  out  1  to DataMem write enable
- mem_addr  out  AW  to DataMem address
- mem_wdata  out  DW  to DataMem write data
- mem_rdata  in  DW  from DataMem, combinational read

## Operation
- States: CORE (core drives memory), HOST (host drives memory).
- CORE: mem_addr/mem_wdata = core signals, mem_we = core_req & core_we; core_stall=0; host_ack=0.
- HOST: mem_addr/mem_wdata = host signals, mem_we = host_we; host_ack=1; host_rdata = mem_rdata; core_stall = core_req.
- wait_cnt (4 bits): in CORE, increments (saturating at STARVE_MAX) when host_req & core_req; cleared on entering HOST and on Reset.
- CORE -> HOST at edge when host_req & (!core_req | wait_cnt == STARVE_MAX-1).
- HOST -> CORE at edge by default. host_req sampled at the edge closing a HOST cycle is ignored (host deasserts after seeing ack).
- burst_cnt counts consecutive HOST cycles; cleared in CORE.
- Simultaneous core_req and host_req with wait_cnt < STARVE_MAX-1: core wins, host waits.
- Address/data widths pass through unmodified; no address decode.

## Timing
- Reset values: state CORE, wait_cnt 0, burst_cnt 0; hence core_stall 0, host_ack 0, mem_we = core_req & core_we.
- Core access latency 0 when not stalled (same-cycle read data, write at closing edge).
- Host latency: 1 cycle with core idle; STARVE_MAX cycles of wait plus 1 with continuous core traffic.
- Non-burst host throughput: one access per 2 cycles max.
- Reset asserted mid-HOST: next cycle CORE; interrupted host access completes its write only if at that edge mem_we was 1 (memory sees it); no ack repeated.
- core_stall deasserts the cycle after the last HOST cycle.

## Configuration
- DMEM_ARB_HOST_BURST_EN defined: in HOST, if host_lock & host_req at the closing edge and burst_cnt < STARVE_MAX-1, stay HOST for another access (one access per cycle); after STARVE_MAX consecutive host cycles, one CORE cycle is forced.
- Undefined: host_lock ignored, burst_cnt absent, HOST always lasts exactly one cycle.

## Structure
- dmem_arb_pkg: state enum (CORE, HOST), counter width constant, default STARVE_MAX.
- One sub-module: arb_sat_counter (enable, clear, saturate at parameter), instanced for wait_cnt and burst_cnt.

## Test plan
- Reset with core_req=1, core_we=1, addr 0x10, data 0xA5 -> mem_we=1, mem_addr 0x10, core_stall 0; next cycle core load of 0x10 returns 0xA5.
- Core idle, host write 0x3C to 0x1F -> host_ack in cycle 2 (1 cycle latency), mem[0x1F]=0x3C, returns to CORE.
- core_req held high continuously, host_req raised cycle 0, STARVE_MAX=4 -> host_ack in cycle 4, core_stall=1 exactly in cycle 4.
- Core and host both write addr 0x05 (0x11, 0x22) with wait_cnt 0 -> core writes first (0x11), then host (0x22); final mem[0x05]=0x22.
- With DMEM_ARB_HOST_BURST_EN, host_lock=1, 10 reads of 0x00..0x09 -> acks in 4 consecutive cycles, 1 CORE cycle, 4 more, 1 CORE, 2; data matches memory.
- Reset pulsed during HOST with core_req=1 -> next cycle CORE, core_stall 0, host_ack 0, wait_cnt 0.
